// File: rtl/div_ctrl_pkg.sv
// Shared state encoding, widths and divider-output field positions for div_ctrl.
package div_ctrl_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned DOUT_W = 64;

  // Divider IP output layout: {quotient, remainder}
  localparam int unsigned QUO_MSB = 63;
  localparam int unsigned QUO_LSB = 32;
  localparam int unsigned REM_MSB = 31;
  localparam int unsigned REM_LSB = 0;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SEND  = 3'd1,
    ST_WAIT  = 3'd2,
    ST_DONE  = 3'd3,
    ST_DRAIN = 3'd4
  } div_state_e;

  function automatic logic [XLEN-1:0] dout_select(input logic [DOUT_W-1:0] dout,
                                                  input logic              want_rem);
    return want_rem ? dout[REM_MSB:REM_LSB] : dout[QUO_MSB:QUO_LSB];
  endfunction

endpackage

// File: rtl/div_ctrl_cache.sv
// Single-entry result cache for div_ctrl; only compiled with DIV_RESULT_CACHE_EN.
`ifdef DIV_RESULT_CACHE_EN
module div_cache
  import div_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              resetn,
  input  logic              wr_en,
  input  logic              wr_signed,
  input  logic [XLEN-1:0]   wr_src1,
  input  logic [XLEN-1:0]   wr_src2,
  input  logic [DOUT_W-1:0] wr_dout,
  input  logic              lk_signed,
  input  logic [XLEN-1:0]   lk_src1,
  input  logic [XLEN-1:0]   lk_src2,
  output logic              hit,
  output logic [DOUT_W-1:0] hit_dout
);

  logic              vld_q, vld_d;
  logic              sgn_q, sgn_d;
  logic [XLEN-1:0]   src1_q, src1_d;
  logic [XLEN-1:0]   src2_q, src2_d;
  logic [DOUT_W-1:0] dout_q, dout_d;

  always_comb begin
    vld_d  = vld_q;
    sgn_d  = sgn_q;
    src1_d = src1_q;
    src2_d = src2_q;
    dout_d = dout_q;
    if (wr_en) begin
      vld_d  = 1'b1;
      sgn_d  = wr_signed;
      src1_d = wr_src1;
      src2_d = wr_src2;
      dout_d = wr_dout;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      vld_q  <= 1'b0;
      sgn_q  <= 1'b0;
      src1_q <= '0;
      src2_q <= '0;
      dout_q <= '0;
    end else begin
      vld_q  <= vld_d;
      sgn_q  <= sgn_d;
      src1_q <= src1_d;
      src2_q <= src2_d;
      dout_q <= dout_d;
    end
  end

  // Both quotient and remainder are kept, so the mod flag does not take part in the match.
  assign hit      = vld_q & (sgn_q == lk_signed) & (src1_q == lk_src1) & (src2_q == lk_src2);
  assign hit_dout = dout_q;

endmodule
`endif

// File: rtl/div_ctrl.sv
// Divide controller between the EX stage and two AXI-Stream divider IPs (signed/unsigned).
// Optional single-entry result cache enabled by defining DIV_RESULT_CACHE_EN.
module div_ctrl
  import div_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              resetn,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_signed,
  input  logic              req_mod,
  input  logic [XLEN-1:0]   req_src1,
  input  logic [XLEN-1:0]   req_src2,
  input  logic              flush,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [XLEN-1:0]   res_data,
  output logic              busy,
  output logic [XLEN-1:0]   div_dividend_tdata,
  output logic [XLEN-1:0]   div_divisor_tdata,
  output logic              sdiv_dividend_tvalid,
  input  logic              sdiv_dividend_tready,
  output logic              sdiv_divisor_tvalid,
  input  logic              sdiv_divisor_tready,
  input  logic              sdiv_dout_tvalid,
  input  logic [DOUT_W-1:0] sdiv_dout_tdata,
  output logic              udiv_dividend_tvalid,
  input  logic              udiv_dividend_tready,
  output logic              udiv_divisor_tvalid,
  input  logic              udiv_divisor_tready,
  input  logic              udiv_dout_tvalid,
  input  logic [DOUT_W-1:0] udiv_dout_tdata
);

  div_state_e      state_q, state_d;
  logic            signed_q, signed_d;
  logic            mod_q, mod_d;
  logic            cancel_q, cancel_d;
  logic            dvd_vld_q, dvd_vld_d;
  logic            dvs_vld_q, dvs_vld_d;
  logic            res_valid_q, res_valid_d;
  logic [XLEN-1:0] src1_q, src1_d;
  logic [XLEN-1:0] src2_q, src2_d;
  logic [XLEN-1:0] res_data_q, res_data_d;

  logic              accept;
  logic              sel_dvd_ready, sel_dvs_ready;
  logic              sel_dout_valid;
  logic [DOUT_W-1:0] sel_dout_data;
  logic              dvd_hs, dvs_hs, dvd_done, dvs_done;
  logic              cache_hit;
  logic [DOUT_W-1:0] cache_dout;

  assign req_ready = (state_q == ST_IDLE) & ~flush;
  assign accept    = req_valid & req_ready;

  // Only the IP chosen by the latched signed flag is ever looked at.
  assign sel_dvd_ready  = signed_q ? sdiv_dividend_tready : udiv_dividend_tready;
  assign sel_dvs_ready  = signed_q ? sdiv_divisor_tready  : udiv_divisor_tready;
  assign sel_dout_valid = signed_q ? sdiv_dout_tvalid     : udiv_dout_tvalid;
  assign sel_dout_data  = signed_q ? sdiv_dout_tdata      : udiv_dout_tdata;

  assign dvd_hs   = dvd_vld_q & sel_dvd_ready;
  assign dvs_hs   = dvs_vld_q & sel_dvs_ready;
  assign dvd_done = ~dvd_vld_q | dvd_hs;
  assign dvs_done = ~dvs_vld_q | dvs_hs;

`ifdef DIV_RESULT_CACHE_EN
  logic cache_wr;
  // Only results that actually reach DONE are cached; drained ones are not.
  assign cache_wr = (state_q == ST_WAIT) & sel_dout_valid & ~flush;

  div_cache u_cache (
    .clk       (clk),
    .resetn    (resetn),
    .wr_en     (cache_wr),
    .wr_signed (signed_q),
    .wr_src1   (src1_q),
    .wr_src2   (src2_q),
    .wr_dout   (sel_dout_data),
    .lk_signed (req_signed),
    .lk_src1   (req_src1),
    .lk_src2   (req_src2),
    .hit       (cache_hit),
    .hit_dout  (cache_dout)
  );
`else
  assign cache_hit  = 1'b0;
  assign cache_dout = '0;
`endif

  always_comb begin
    state_d     = state_q;
    signed_d    = signed_q;
    mod_d       = mod_q;
    cancel_d    = cancel_q;
    dvd_vld_d   = dvd_vld_q;
    dvs_vld_d   = dvs_vld_q;
    res_valid_d = res_valid_q;
    src1_d      = src1_q;
    src2_d      = src2_q;
    res_data_d  = res_data_q;

    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          signed_d = req_signed;
          mod_d    = req_mod;
          src1_d   = req_src1;
          src2_d   = req_src2;
          if (cache_hit) begin
            state_d     = ST_DONE;
            res_valid_d = 1'b1;
            res_data_d  = dout_select(cache_dout, req_mod);
          end else begin
            state_d   = ST_SEND;
            dvd_vld_d = 1'b1;
            dvs_vld_d = 1'b1;
          end
        end
      end
      ST_SEND: begin
        // A flush cannot retract a tvalid; remember it and drain once both beats are taken.
        dvd_vld_d = dvd_vld_q & ~dvd_hs;
        dvs_vld_d = dvs_vld_q & ~dvs_hs;
        cancel_d  = cancel_q | flush;
        if (dvd_done && dvs_done) begin
          state_d = cancel_d ? ST_DRAIN : ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (sel_dout_valid) begin
          if (flush) begin
            state_d = ST_IDLE;
          end else begin
            state_d     = ST_DONE;
            res_valid_d = 1'b1;
            res_data_d  = dout_select(sel_dout_data, mod_q);
          end
        end else if (flush) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DONE: begin
        if (flush || res_ready) begin
          state_d     = ST_IDLE;
          res_valid_d = 1'b0;
        end
      end
      ST_DRAIN: begin
        if (sel_dout_valid) begin
          state_d  = ST_IDLE;
          cancel_d = 1'b0;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        res_valid_d = 1'b0;
        dvd_vld_d   = 1'b0;
        dvs_vld_d   = 1'b0;
        cancel_d    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q     <= ST_IDLE;
      signed_q    <= 1'b0;
      mod_q       <= 1'b0;
      cancel_q    <= 1'b0;
      dvd_vld_q   <= 1'b0;
      dvs_vld_q   <= 1'b0;
      res_valid_q <= 1'b0;
      src1_q      <= '0;
      src2_q      <= '0;
      res_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      signed_q    <= signed_d;
      mod_q       <= mod_d;
      cancel_q    <= cancel_d;
      dvd_vld_q   <= dvd_vld_d;
      dvs_vld_q   <= dvs_vld_d;
      res_valid_q <= res_valid_d;
      src1_q      <= src1_d;
      src2_q      <= src2_d;
      res_data_q  <= res_data_d;
    end
  end

  assign sdiv_dividend_tvalid = dvd_vld_q &  signed_q;
  assign sdiv_divisor_tvalid  = dvs_vld_q &  signed_q;
  assign udiv_dividend_tvalid = dvd_vld_q & ~signed_q;
  assign udiv_divisor_tvalid  = dvs_vld_q & ~signed_q;

  assign div_dividend_tdata = src1_q;
  assign div_divisor_tdata  = src2_q;

  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;
  assign busy      = (state_q != ST_IDLE);

endmodule

// File: doc/div_ctrl.md
DIV_CTRL -- requirements
Module: div_ctrl

Interface
REQ-001 SHALL have: clk  in  1  clock, all logic on posedge.
REQ-002 SHALL have: resetn  in  1  reset; synchronous, active-low.
REQ-003 SHALL have: req_valid  in  1  EX-stage divide request valid.
REQ-004 SHALL have: req_ready  out  1  controller accepts request this cycle.
REQ-005 SHALL have: req_signed  in  1  1=div.w/mod.w, 0=div.wu/mod.wu.
REQ-006 SHALL have: req_mod  in  1  1=return remainder, 0=quotient.
REQ-007 SHALL have: req_src1, req_src2  in  32 each  dividend, divisor.
REQ-008 SHALL have: flush  in  1  exception/ertn flush; cancels in-flight op.
REQ-009 SHALL have: res_valid  out  1  result available; res_ready  in  1  consumer takes it.
REQ-010 SHALL have: res_data  out  32  selected quotient or remainder.
REQ-011 SHALL have: busy  out  1  state != IDLE.
REQ-012 SHALL have: div_dividend_tdata, div_divisor_tdata  out  32 each  operands, shared by both divider IPs.
REQ-013 SHALL have per IP x in {sdiv, udiv}: x_dividend_tvalid out 1, x_dividend_tready in 1, x_divisor_tvalid out 1, x_divisor_tready in 1, x_dout_tvalid in 1, x_dout_tdata in 64 ({quotient, remainder}).

Function
REQ-014 SHALL implement states IDLE, SEND, WAIT, DONE, DRAIN (one-hot or binary).
REQ-015 SHALL assert req_ready = (state==IDLE) & ~flush; accept = req_valid & req_ready latches signed, mod, src1, src2; IDLE->SEND.
REQ-016 SHALL in SEND assert only the selected IP's two tvalids; each tvalid drops independently on its own tvalid&tready; tdata stable while any tvalid high.
REQ-017 SHALL leave SEND when both channels have handshaken (same or different cycles) -> WAIT, or -> DRAIN if cancel flag set.
REQ-018 SHALL in WAIT, on selected x_dout_tvalid, register res_data = req_mod ? dout[31:0] : dout[63:32] and go to DONE; res_valid registered, first high the cycle after dout_tvalid.
REQ-019 SHALL in DONE hold res_valid and res_data stable until res_ready; res_valid&res_ready -> IDLE.
REQ-020 SHALL on flush: IDLE no effect; SEND set cancel flag, keep tvalids until handshake (AXI rule); WAIT -> DRAIN; DONE -> IDLE, result dropped; DRAIN no effect.
REQ-021 SHALL in DRAIN keep res_valid=0, discard selected dout on x_dout_tvalid, -> IDLE, clear cancel flag.
REQ-022 SHALL ignore dout_tvalid of the non-selected IP and any dout_tvalid outside WAIT/DRAIN.
REQ-023 SHALL pass divide-by-zero and 0x80000000/-1 unchanged from IP output; no exception generated.

Reset
REQ-024 SHALL on resetn=0 at posedge: state=IDLE, all tvalids=0, res_valid=0, res_data=0, cancel=0, cache valid=0; reset overrides flush and mid-operation state; busy=0.
REQ-025 SHALL not require divider IP reset; stale dout_tvalid after reset ignored per REQ-022.

Configuration
REQ-026 SHALL with DIV_RESULT_CACHE_EN defined keep one entry {signed, src1, src2, quotient, remainder}, written at WAIT->DONE; accepted request matching signed/src1/src2 goes IDLE->DONE next cycle with no IP tvalid; entry invalidated only by reset; drained results not written.
REQ-027 SHALL without DIV_RESULT_CACHE_EN contain no cache storage; every request uses the IP path.

Structure
REQ-028 SHALL place state encoding constants and the 64-bit dout split positions (quotient [63:32], remainder [31:0]) in the shared width/define header package.
REQ-029 SHALL be a single module; optional sub-module div_cache only under DIV_RESULT_CACHE_EN.

Verification
REQ-030 SHALL cover: signed, mod=0, -7/2 -> res_data 0xFFFFFFFD; same with mod=1 -> 0xFFFFFFFF.
REQ-031 SHALL cover: unsigned 0xFFFFFFFF/16, mod=0 -> 0x0FFFFFFF; sdiv tvalids stay 0.
REQ-032 SHALL cover: dividend_tready low 3 cycles, divisor_tready immediate -> divisor_tvalid drops after 1 cycle, dividend_tvalid held 4 cycles, tdata stable.
REQ-033 SHALL cover: flush in WAIT -> no res_valid, req_ready=0 until dout_tvalid, next request 100/7 returns 14.
REQ-034 SHALL cover: res_ready low 5 cycles in DONE -> res_valid/res_data held; with DIV_RESULT_CACHE_EN, repeat 100/7 -> res_valid 1 cycle after accept, no IP tvalid.
